// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one accelerator FSM at a time, muxes its command
// word onto the bus and holds ownership until an ACK arrives or the watchdog fires.
module bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDRW   = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*(ADDRW+8)-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  input  logic [2:0]                   ack_in,
  output logic [ADDRW+7:0]             bus_data,
  output logic                         bus_valid,
  output logic                         busy,
  output logic [2:0]                   owner,
  output logic                         timeout_err
);

  localparam int         CW        = ADDRW + 8;
  localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_INIT = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] wdCount_q, wdCount_d;
  logic        timeoutErr_q, timeoutErr_d;

  logic [2:0]  winner;
  logic        winnerFound;
  int          cand;

  logic        unusedAckId;
  assign unusedAckId = ^ack_in[1:0];

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    winner      = '0;
    winnerFound = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!winnerFound && cand == j && req[j]) begin
          winner      = 3'(j);
          winnerFound = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wdCount_d    = wdCount_q;
    timeoutErr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winnerFound) begin
          owner_d = winner;
          last_d  = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wdCount_d = '0;
        state_d   = ST_BUSY;
      end
      ST_BUSY: begin
        wdCount_d = wdCount_q + 16'd1;
        // ACK takes priority over a watchdog expiry in the same cycle.
        if (ack_in[2]) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0 && wdCount_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          timeoutErr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_q       <= LAST_INIT;
      wdCount_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      wdCount_q    <= wdCount_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // Bus-facing outputs depend only on registered state/owner (plus the data mux).
  always_comb begin
    grant     = '0;
    bus_valid = 1'b0;
    busy      = 1'b0;
    bus_data  = '0;
    if (state_q == ST_GRANT || state_q == ST_BUSY) begin
      busy = 1'b1;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (owner_q == 3'(j)) bus_data = req_data[j*CW +: CW];
      end
    end
    if (state_q == ST_GRANT) begin
      bus_valid = 1'b1;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (owner_q == 3'(j)) grant[j] = 1'b1;
      end
    end
  end

  assign owner       = owner_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 requesters, 24-bit address, watchdog of 4 cycles):
// a vector table for the main flow plus hand sequences for reset and an AES-style burst.
module tb_bus_arbiter;

  localparam logic [31:0] D0 = 32'h0123_4567;
  localparam logic [31:0] D1 = 32'hABCD_EF12;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] req_data;
  logic [1:0]  grant;
  logic [2:0]  ack_in;
  logic [31:0] bus_data;
  logic        bus_valid;
  logic        busy;
  logic [2:0]  owner;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int grantCycles = 0;
  bit countEn = 1'b0;

  bus_arbiter #(.NUM_REQ(2), .ADDRW(24), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .ack_in(ack_in), .bus_data(bus_data), .bus_valid(bus_valid), .busy(busy),
    .owner(owner), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (countEn && grant != 2'b00) grantCycles++;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  ack;
    logic [1:0]  grant;
    logic        valid;
    logic        busy;
    logic [2:0]  owner;
    logic        terr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [1:0] r, input logic [2:0] a, input logic [1:0] g,
                        input logic v, input logic b, input logic [2:0] o,
                        input logic t, input logic [31:0] d);
    vec_t x;
    x.req = r; x.ack = a; x.grant = g; x.valid = v; x.busy = b;
    x.owner = o; x.terr = t; x.data = d;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [2:0] a);
    req    = r;
    ack_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] g, input logic v, input logic b,
                          input logic [2:0] o, input logic t, input logic [31:0] d);
    checkOutput({tag, " grant"}, 32'(grant), 32'(g));
    checkOutput({tag, " bus_valid"}, 32'(bus_valid), 32'(v));
    checkOutput({tag, " busy"}, 32'(busy), 32'(b));
    checkOutput({tag, " owner"}, 32'(owner), 32'(o));
    checkOutput({tag, " timeout_err"}, 32'(timeout_err), 32'(t));
    checkOutput({tag, " bus_data"}, bus_data, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [31:0] aesData [4];
    logic [1:0]  aesId   [4];
    bit          gotGrant;

    rst = 1'b1; req = '0; ack_in = '0; req_data = {D1, D0};
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    rst = 1'b0;

    // single transaction on requester 1; ACK coincides with the 4th BUSY cycle
    addVec(2'b10, 3'b000, 2'b10, 1, 1, 3'd1, 0, D1);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b00, 3'b100, 2'b00, 0, 0, 3'd1, 0, 32'h0);
    addVec(2'b00, 3'b000, 2'b00, 0, 0, 3'd1, 0, 32'h0);
    // watchdog release after 4 BUSY cycles
    addVec(2'b01, 3'b000, 2'b01, 1, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 0, 3'd0, 1, 32'h0);
    addVec(2'b00, 3'b000, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    // fairness with both requesting
    addVec(2'b11, 3'b000, 2'b10, 1, 1, 3'd1, 0, D1);
    addVec(2'b11, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b11, 3'b100, 2'b00, 0, 0, 3'd1, 0, 32'h0);
    addVec(2'b11, 3'b000, 2'b01, 1, 1, 3'd0, 0, D0);
    addVec(2'b11, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b11, 3'b100, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    addVec(2'b11, 3'b000, 2'b10, 1, 1, 3'd1, 0, D1);
    addVec(2'b11, 3'b000, 2'b00, 0, 1, 3'd1, 0, D1);
    addVec(2'b11, 3'b100, 2'b00, 0, 0, 3'd1, 0, 32'h0);
    addVec(2'b11, 3'b000, 2'b01, 1, 1, 3'd0, 0, D0);
    // stale ACK in GRANT ignored, owner's req drop ignored
    addVec(2'b11, 3'b110, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b101, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    addVec(2'b00, 3'b000, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    // ACK in IDLE ignored; lone requester wins repeatedly
    addVec(2'b00, 3'b100, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    addVec(2'b01, 3'b100, 2'b01, 1, 1, 3'd0, 0, D0);
    addVec(2'b01, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b01, 3'b100, 2'b00, 0, 0, 3'd0, 0, 32'h0);
    addVec(2'b01, 3'b000, 2'b01, 1, 1, 3'd0, 0, D0);
    addVec(2'b01, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b000, 2'b00, 0, 1, 3'd0, 0, D0);
    addVec(2'b00, 3'b100, 2'b00, 0, 0, 3'd0, 0, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].ack);
      checkAll($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].busy,
               vecs[i].owner, vecs[i].terr, vecs[i].data);
    end

    // async reset mid-BUSY with both requesting, then requester 0 wins first
    applyStimulus(2'b11, 3'b000);
    checkOutput("pre-reset grant", 32'(grant), 32'(2'b10));
    applyStimulus(2'b11, 3'b000);
    #2 rst = 1'b1;
    #1;
    checkAll("in-reset", 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkAll("held-reset", 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(2'b11, 3'b000);
    checkOutput("post-reset grant", 32'(grant), 32'(2'b01));
    applyStimulus(2'b00, 3'b000);
    applyStimulus(2'b00, 3'b100);
    checkOutput("post-reset release busy", 32'(busy), 32'h0);

    // AES-style burst: four separate grants for requester 0
    aesData[0] = 32'hA000_0010; aesData[1] = 32'hA000_0020;
    aesData[2] = 32'hA000_0030; aesData[3] = 32'hA000_0040;
    aesId[0] = 2'b00; aesId[1] = 2'b00; aesId[2] = 2'b10; aesId[3] = 2'b00;
    grantCycles = 0;
    countEn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      req_data = {D1, aesData[t]};
      gotGrant = 1'b0;
      for (int w = 0; w < 8 && !gotGrant; w++) begin
        applyStimulus(2'b01, 3'b000);
        if (grant == 2'b01) gotGrant = 1'b1;
      end
      checkOutput($sformatf("aes%0d granted", t), 32'(gotGrant), 32'h1);
      checkOutput($sformatf("aes%0d grant data", t), bus_data, aesData[t]);
      applyStimulus(2'b00, 3'b000);
      checkOutput($sformatf("aes%0d grant width", t), 32'(grant), 32'h0);
      checkOutput($sformatf("aes%0d busy data", t), bus_data, aesData[t]);
      applyStimulus(2'b00, 3'b000);
      checkOutput($sformatf("aes%0d stable data", t), bus_data, aesData[t]);
      applyStimulus(2'b00, {1'b1, aesId[t]});
      checkOutput($sformatf("aes%0d released", t), 32'(busy), 32'h0);
    end
    @(negedge clk);
    countEn = 1'b0;
    checkOutput("aes grant cycles", 32'(grantCycles), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared command/data bus between the accelerator control FSMs (AES, SHA, …) and memory. It grants one requester at a time, muxes that requester's command word onto the bus, and holds ownership until the completion ACK arrives or a watchdog expires. It sits between the accelerator FSMs' `arb_req`/`arb_grant`/`data_out` ports and the bus, and also sees the bus `ack_in` lines.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesting FSMs (2–8).
- `ADDRW`, 24: address width. A command word is ADDRW+8 bits.
- `TIMEOUT`, 255: maximum number of BUSY cycles before a forced release. 0 disables the watchdog. The counter is 16 bits wide.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  `arb_req` from each FSM.
- `req_data`  in  NUM_REQ*(ADDRW+8)  concatenated `data_out` of each FSM; slice i is bits [(i+1)*(ADDRW+8)-1 : i*(ADDRW+8)].
- `grant`  out  NUM_REQ  one-hot `arb_grant` to each FSM.
- `ack_in`  in  3  bus ACK: bit 2 is the valid bit, bits [1:0] are the responder ID.
- `bus_data`  out  ADDRW+8  command word driven onto the bus.
- `bus_valid`  out  1  the command word on `bus_data` is being issued this cycle.
- `busy`  out  1  the bus is owned (GRANT or BUSY state).
- `owner`  out  3  index of the current/last owner.
- `timeout_err`  out  1  one-cycle pulse on a watchdog release.

## Operation
States:
- **IDLE**
  - If any `req` bit is set, pick the winner by round-robin, starting at index `last+1` modulo NUM_REQ.
  - Register `owner = winner` and `last = winner`, then go to GRANT.
  - If no `req` bit is set, stay in IDLE.
- **GRANT** (exactly 1 cycle)
  - `grant[owner]=1`, `bus_valid=1`, `bus_data` = slice `owner` of `req_data`.
  - Clear the watchdog counter and go to BUSY unconditionally.
- **BUSY**
  - `grant=0`, `bus_valid=0`; `bus_data` stays muxed from slice `owner`, which the FSM keeps driving in its WAIT state.
  - Counter increments each cycle.
  - If `ack_in[2]=1` (any ID), go to IDLE.
  - Else if TIMEOUT≠0 and counter reaches TIMEOUT-1, go to IDLE and pulse `timeout_err`.

General rules:
- `grant`, `bus_valid` and `busy` are decoded from registered state and owner only, so there is no combinational path from `req`.
- Every bus transaction is one grant. An FSM needing four transactions re-requests four times and competes each time.
- Outputs in IDLE: `grant=0`, `bus_valid=0`, `bus_data=0`, `busy=0`.
- `owner` holds its value in IDLE.
- An unknown or illegal state returns to IDLE.

## Timing
Reset values:
- Async `rst` forces IDLE, `owner=0`, `last=NUM_REQ-1` (so requester 0 wins first), counter=0.
- All outputs are 0 during and after reset, including when reset hits in GRANT or BUSY.

Latency and throughput:
- From `req` high in IDLE at edge N, `grant` is high during cycle N+1.
- The FSM samples `grant` at edge N+2 and drops `req`.
- After ACK at edge M, the arbiter is in IDLE in cycle M+1. The earliest next grant is cycle M+2, so back-to-back transactions have a 1-cycle IDLE gap.

Boundary conditions:
- ACK during GRANT or IDLE is ignored; only an ACK during BUSY releases the bus.
- ACK and timeout in the same cycle: treat as ACK, with no `timeout_err`.
- `req` dropping during GRANT or BUSY is ignored; ownership is released only by ACK or timeout.
- `req` of the owner still high after release means it is a new request and competes normally.
- Requests arriving during BUSY wait and are not lost (they are levels).
- A single requester may win repeatedly when it is the only one asserting.
- `last` wraps from NUM_REQ-1 to 0.

## Test plan
- **Reset:** assert `rst` mid-BUSY with `req=2'b11` → next cycle `grant=0`, `busy=0`, `bus_data=0`; after release, `req=2'b11` grants requester 0 first.
- **Single transaction:** `req[1]` high at edge 0 with `req_data` slice 1 = `0xABCDEF_12` → `grant=2'b10`, `bus_valid=1`, `bus_data=0xABCDEF12` in cycle 1, `busy=1` in cycles 1..k. ACK `3'b100` in cycle 5 → IDLE in cycle 6.
- **Fairness:** hold `req=2'b11` with ACKs returned 2 cycles after each grant → grant sequence 0,1,0,1 with no repeats.
- **Stale ACK:** `ack_in=3'b110` in the GRANT cycle → ignored, arbiter stays BUSY until the next ACK.
- **Watchdog:** TIMEOUT=4, no ACK → release after 4 BUSY cycles, `timeout_err` pulses exactly once. ACK coincident with the 4th cycle → no `timeout_err`.
- **Full AES-style sequence:** four grant/ACK pairs (ACK IDs 00, 00, 10, 00) against a requester model → exactly 4 grants, each one cycle wide, `bus_data` stable through each BUSY.
